// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store. It buffers the
// fetched instruction and the load data, and freezes the whole pipeline until both are ready.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_ins_o,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_re_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  mem_f3_i,
    output logic [31:0] mem_rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [2:0]  bus_f3_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [4:0]  stall_o,
    output logic        bus_err_o
);

    localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);
    localparam logic [2:0]      F3_WORD  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        ins_buf_q, ins_buf_d;
    logic [31:0]        ins_addr_q, ins_addr_d;
    logic               ins_valid_q, ins_valid_d;
    logic [31:0]        rdata_buf_q, rdata_buf_d;
    logic               dat_done_q, dat_done_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic [2:0]         bus_f3_q, bus_f3_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic ins_hit;
    logic dat_need;
    logic advance;

    assign ins_hit  = ins_valid_q && (ins_addr_q == if_addr_i);
    assign dat_need = (mem_re_i || mem_wr_i) && !dat_done_q;
    assign advance  = ins_hit && !dat_need;

    assign stall_o     = advance ? 5'b00000 : 5'b11111;
    assign bus_req_o   = (state_q != IDLE);
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_f3_o    = bus_f3_q;
    assign if_ins_o    = ins_buf_q;
    assign mem_rdata_o = rdata_buf_q;
    assign bus_err_o   = err_q;

    // Next-state: data access wins over fetch because it belongs to the older instruction.
    always_comb begin
        state_d     = state_q;
        ins_buf_d   = ins_buf_q;
        ins_addr_d  = ins_addr_q;
        ins_valid_d = ins_valid_q;
        rdata_buf_d = rdata_buf_q;
        dat_done_d  = dat_done_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_f3_d    = bus_f3_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        if (advance) begin
            dat_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (dat_need) begin
                    state_d     = DATA;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                    bus_f3_d    = mem_f3_i;
                    bus_we_d    = mem_wr_i;
                end else if (!ins_hit) begin
                    state_d    = FETCH;
                    bus_addr_d = if_addr_i;
                    bus_we_d   = 1'b0;
                    bus_f3_d   = F3_WORD;
                end
            end
            FETCH, DATA: begin
                if (bus_ack_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (state_q == FETCH) begin
                        ins_buf_d   = bus_rdata_i;
                        ins_addr_d  = bus_addr_q;
                        ins_valid_d = 1'b1;
                    end else begin
                        if (!bus_we_q) begin
                            rdata_buf_d = bus_rdata_i;
                        end
                        dat_done_d = 1'b1;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    // Give up on this attempt; IDLE re-issues the same access.
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ins_buf_q   <= '0;
            ins_addr_q  <= '0;
            ins_valid_q <= 1'b0;
            rdata_buf_q <= '0;
            dat_done_q  <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_f3_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ins_buf_q   <= ins_buf_d;
            ins_addr_q  <= ins_addr_d;
            ins_valid_q <= ins_valid_d;
            rdata_buf_q <= rdata_buf_d;
            dat_done_q  <= dat_done_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_f3_q    <= bus_f3_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a bus responder with configurable wait states, and a
// monitor that checks each bus transfer and each stall-to-advance against queued expectations.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] if_addr_i;
    logic [31:0] if_ins_o;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_re_i;
    logic        mem_wr_i;
    logic [2:0]  mem_f3_i;
    logic [31:0] mem_rdata_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [2:0]  bus_f3_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic [4:0]  stall_o;
    logic        bus_err_o;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_addr_i   (if_addr_i),
        .if_ins_o    (if_ins_o),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_re_i    (mem_re_i),
        .mem_wr_i    (mem_wr_i),
        .mem_f3_i    (mem_f3_i),
        .mem_rdata_o (mem_rdata_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_f3_o    (bus_f3_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .stall_o     (stall_o),
        .bus_err_o   (bus_err_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        cmp_wd;
        logic [2:0]  f3;
    } bus_exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] rdata;
        int          len;
    } adv_exp_t;

    bus_exp_t exp_bus[$];
    adv_exp_t exp_adv[$];

    int n_vec = 0;
    int n_bad = 0;

    logic        ack_en    = 1'b1;
    logic        force_ack = 1'b0;
    int          bus_wait  = 0;
    logic [31:0] rdata_val = '0;
    int          wait_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic cmp_wd, input logic [2:0] f3);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wd; e.cmp_wd = cmp_wd; e.f3 = f3;
        exp_bus.push_back(e);
    endtask

    task automatic push_adv(input logic [31:0] ins, input logic [31:0] rd, input int len);
        adv_exp_t e;
        e.ins = ins; e.rdata = rd; e.len = len;
        exp_adv.push_back(e);
    endtask

    task automatic wait_adv(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_o != 5'd0 && n < 60);
        if (stall_o != 5'd0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no advance within 60 cycles, stall_o=%b required 00000", name, stall_o);
        end
    endtask

    // Bus responder: acks after bus_wait request cycles; force_ack pulses regardless of request.
    initial begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (force_ack) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = rdata_val;
            end else if (ack_en && bus_req_o && !rst && wait_cnt >= bus_wait) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = rdata_val;
                wait_cnt    = 0;
            end else begin
                bus_ack_i = 1'b0;
                if (bus_req_o) wait_cnt++;
                else wait_cnt = 0;
            end
        end
    end

    // Monitor: scoreboard for bus transfers and stall episodes.
    initial begin
        int stall_cnt;
        bus_exp_t b;
        adv_exp_t a;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0;
            end else begin
                if (bus_req_o && bus_ack_i) begin
                    if (exp_bus.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL bus_unexpected: got access addr %08h expected none", bus_addr_o);
                    end else begin
                        b = exp_bus.pop_front();
                        chk("bus_we", 32'(bus_we_o), 32'(b.we));
                        chk("bus_addr", bus_addr_o, b.addr);
                        chk("bus_f3", 32'(bus_f3_o), 32'(b.f3));
                        if (b.cmp_wd) chk("bus_wdata", bus_wdata_o, b.wdata);
                    end
                end
                if (stall_o != 5'd0) begin
                    chk("stall_full", 32'(stall_o), 32'h1F);
                    stall_cnt++;
                end else if (stall_cnt != 0) begin
                    if (exp_adv.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL adv_unexpected: got advance after %0d stalls expected none", stall_cnt);
                    end else begin
                        a = exp_adv.pop_front();
                        chk("stall_len", 32'(stall_cnt), 32'(a.len));
                        chk("if_ins", if_ins_o, a.ins);
                        chk("mem_rdata", mem_rdata_o, a.rdata);
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t expected earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stall"}, 32'(stall_o), 32'h1F);
        chk({tag, "_req"}, 32'(bus_req_o), 32'd0);
        chk({tag, "_we"}, 32'(bus_we_o), 32'd0);
        chk({tag, "_addr"}, bus_addr_o, 32'd0);
        chk({tag, "_wdata"}, bus_wdata_o, 32'd0);
        chk({tag, "_f3"}, 32'(bus_f3_o), 32'd0);
        chk({tag, "_ins"}, if_ins_o, 32'd0);
        chk({tag, "_rdata"}, mem_rdata_o, 32'd0);
        chk({tag, "_err"}, 32'(bus_err_o), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        if_addr_i   = 32'h0800_0000;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        mem_re_i    = 1'b0;
        mem_wr_i    = 1'b0;
        mem_f3_i    = 3'b010;
        rdata_val   = 32'h0050_0093;

        // Reset fetch, zero-wait bus
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        push_bus(1'b0, 32'h0800_0000, '0, 1'b0, 3'b010);
        push_adv(32'h0050_0093, 32'h0, 2);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_adv("reset_fetch");

        // Load with instruction hit, 3 wait states
        @(posedge clk); #1;
        mem_re_i   = 1'b1;
        mem_addr_i = 32'h0000_0010;
        bus_wait   = 3;
        rdata_val  = 32'hDEAD_BEEF;
        push_bus(1'b0, 32'h0000_0010, '0, 1'b0, 3'b010);
        push_adv(32'h0050_0093, 32'hDEAD_BEEF, 5);
        wait_adv("load_hit");

        // Back-to-back load: needs a fresh access, so dat_done must have cleared
        @(posedge clk); #1;
        mem_addr_i = 32'h0000_0014;
        bus_wait   = 0;
        rdata_val  = 32'hCAFE_F00D;
        push_bus(1'b0, 32'h0000_0014, '0, 1'b0, 3'b010);
        push_adv(32'h0050_0093, 32'hCAFE_F00D, 2);
        wait_adv("load_again");

        // Store plus instruction miss: store first, then fetch
        @(posedge clk); #1;
        mem_re_i    = 1'b0;
        mem_wr_i    = 1'b1;
        mem_addr_i  = 32'h0000_0020;
        mem_wdata_i = 32'h1234_5678;
        mem_f3_i    = 3'b000;
        if_addr_i   = 32'h0800_0004;
        rdata_val   = 32'h00A0_0113;
        push_bus(1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 3'b000);
        push_bus(1'b0, 32'h0800_0004, '0, 1'b0, 3'b010);
        push_adv(32'h00A0_0113, 32'hCAFE_F00D, 4);
        wait_adv("store_miss");

        // Sequential fetch then branch redirect
        @(posedge clk); #1;
        mem_wr_i  = 1'b0;
        mem_f3_i  = 3'b010;
        if_addr_i = 32'h0800_0008;
        rdata_val = 32'h0000_0013;
        push_bus(1'b0, 32'h0800_0008, '0, 1'b0, 3'b010);
        push_adv(32'h0000_0013, 32'hCAFE_F00D, 2);
        wait_adv("seq_fetch");
        @(posedge clk); #1;
        if_addr_i = 32'h0800_0040;
        rdata_val = 32'h0000_006F;
        push_bus(1'b0, 32'h0800_0040, '0, 1'b0, 3'b010);
        push_adv(32'h0000_006F, 32'hCAFE_F00D, 2);
        wait_adv("branch");

        // Timeout: 4 unacked FETCH cycles, back to IDLE, retry, then ack
        @(posedge clk); #1;
        ack_en    = 1'b0;
        if_addr_i = 32'h0800_0044;
        rdata_val = 32'h0000_0093;
        push_bus(1'b0, 32'h0800_0044, '0, 1'b0, 3'b010);
        push_adv(32'h0000_0093, 32'hCAFE_F00D, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("err_before_timeout", 32'(bus_err_o), 32'd0);
        end
        @(negedge clk);
        chk("err_at_timeout", 32'(bus_err_o), 32'd1);
        chk("req_idle_after_timeout", 32'(bus_req_o), 32'd0);
        @(negedge clk);
        chk("req_retry", 32'(bus_req_o), 32'd1);
        chk("retry_addr", bus_addr_o, 32'h0800_0044);
        ack_en = 1'b1;
        wait_adv("timeout_retry");
        chk("err_sticky", 32'(bus_err_o), 32'd1);

        // Reset during a DATA wait, stray ack right after release
        @(posedge clk); #1;
        ack_en     = 1'b0;
        mem_re_i   = 1'b1;
        mem_addr_i = 32'h0000_0030;
        rdata_val  = 32'h0010_0073;
        @(negedge clk);
        @(negedge clk);
        chk("data_wait_req", 32'(bus_req_o), 32'd1);
        chk("data_wait_addr", bus_addr_o, 32'h0000_0030);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        force_ack = 1'b1;
        push_bus(1'b0, 32'h0000_0030, '0, 1'b0, 3'b010);
        push_bus(1'b0, 32'h0800_0044, '0, 1'b0, 3'b010);
        push_adv(32'h0010_0073, 32'h0010_0073, 4);
        @(negedge clk);
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        force_ack = 1'b0;
        ack_en    = 1'b1;
        @(negedge clk);
        chk("post_rst_data_req", 32'(bus_req_o), 32'd1);
        chk("post_rst_data_addr", bus_addr_o, 32'h0000_0030);
        chk("post_rst_ins_kept", if_ins_o, 32'd0);
        wait_adv("reset_mid_access");

        @(posedge clk); #1;
        mem_re_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        chk("adv_queue_drained", 32'(exp_adv.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and pipeline sequencer for the 5-stage RISC-V core on the DE0-Nano. It shares one memory bus between the IF stage's instruction fetch and the MEM stage's load/store. It buffers the fetched instruction and the load data, and drives the pipeline `stall` bus so that every stage freezes until both accesses for the current cycle are satisfied. It replaces the hard-wired zero `stall` bus and the separate async I/D memories.

## Interface
- `TIMEOUT`, 255: maximum cycles to wait for `bus_ack_i` per access; 0 disables the timeout.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `if_addr_i` in 32: current PC (`pc_reg.pc`).
- `if_ins_o` out 32: buffered instruction for `if_addr_i`; valid when `stall_o == 0`.
- `mem_addr_i` in 32: EX/MEM ALU result.
- `mem_wdata_i` in 32: EX/MEM store data.
- `mem_re_i` in 1: EX/MEM load request.
- `mem_wr_i` in 1: EX/MEM store request.
- `mem_f3_i` in 3: EX/MEM funct3 (size/sign).
- `mem_rdata_o` out 32: buffered load data; valid when `stall_o == 0`.
- `bus_req_o` out 1: bus request, held until ack.
- `bus_we_o` out 1: 1 = store.
- `bus_addr_o` out 32: bus address.
- `bus_wdata_o` out 32: bus write data.
- `bus_f3_o` out 3: bus funct3; `3'b010` for fetches.
- `bus_ack_i` in 1: single-cycle completion pulse; read data is valid in the same cycle.
- `bus_rdata_i` in 32: bus read data.
- `stall_o` out 5: `StallBus`. Bit0 = PC, bit1 = IF/ID, bit2 = ID/EX, bit3 = EX/MEM, bit4 = MEM/WB.
- `bus_err_o` out 1: sticky timeout flag; cleared only by `rst`.

## Operation
- **Internal state**
  - Fetch buffer: `ins_buf`, `ins_addr`, `ins_valid`.
  - Data buffer: `rdata_buf`, `dat_done`.
  - FSM with states IDLE, FETCH, DATA.
  - Wait counter.
- **Derived signals**
  - `ins_hit = ins_valid && ins_addr == if_addr_i`.
  - `dat_need = (mem_re_i | mem_wr_i) && !dat_done`.
  - `advance = ins_hit && !dat_need`.
- **Stall output:** `stall_o = advance ? 5'b00000 : 5'b11111`. This is a full freeze, combinational from the registered state and the inputs.
- **IDLE state**
  - If `dat_need`, go to DATA. Latch `mem_addr_i`, `mem_wdata_i`, `mem_f3_i`, and `bus_we_o = mem_wr_i`. Data has priority because it is the older instruction.
  - Otherwise, if `!ins_hit`, go to FETCH. Latch `if_addr_i`, set `bus_we_o = 0`, `bus_f3_o = 3'b010`.
  - Otherwise, stay in IDLE.
- **FETCH / DATA states**
  - `bus_req_o = 1`. All bus fields stay stable until ack.
  - On `bus_ack_i` in FETCH: `ins_buf <= bus_rdata_i`, `ins_addr <=` latched address, `ins_valid <= 1`, go to IDLE.
  - On `bus_ack_i` in DATA: `rdata_buf <= bus_rdata_i` (loads only; stores leave it unchanged), `dat_done <= 1`, go to IDLE.
- **`dat_done`:** cleared on any `advance` cycle, so the next instruction entering MEM gets a fresh access. `ins_valid` is never cleared except by reset. A PC change (sequential or branch) is detected by the address compare.
- **Timeout:** the wait counter counts cycles in FETCH/DATA and resets on entry. If it reaches `TIMEOUT` (nonzero) without ack: set `bus_err_o`, return to IDLE, and retry normally.
- **Ignored ack:** `bus_ack_i` in IDLE is ignored.
- **PC change mid-fetch:** if `if_addr_i` changes while a FETCH is in flight, the in-flight fetch completes. The address compare then misses and a new fetch is issued. This cannot happen under full freeze, but the design must be robust to it.
- **Load and miss together:** a load and an instruction miss in the same cycle cost two serialized accesses, DATA first.

## Timing
- **Reset values:** state IDLE, `bus_req_o = 0`, `bus_we_o = 0`, `bus_addr_o = 0`, `bus_wdata_o = 0`, `bus_f3_o = 0`, `ins_valid = 0`, `dat_done = 0`, `ins_buf = 0`, `rdata_buf = 0`, `if_ins_o = 0`, `mem_rdata_o = 0`, `bus_err_o = 0`, counter 0.
  - Because `ins_valid = 0`, `stall_o = 5'b11111` in the first cycle after reset.
- **Reset asserted mid-access:** the access is abandoned and the state returns to IDLE on the next edge. A later `bus_ack_i` is ignored.
- **Zero-wait bus (ack in the first `bus_req_o` cycle)**
  - Instruction miss: 2 stall cycles (IDLE→FETCH, FETCH ack→IDLE). Advance happens in the 3rd cycle.
  - Load/store plus instruction hit: 2 stall cycles.
  - Load plus instruction miss: 4 stall cycles.
- **N-wait bus:** each access adds N cycles.
- **Minimum request duration:** `bus_req_o` is high for at least 1 cycle per access, and the bus sees exactly one request per ack.
- **Output validity:** `if_ins_o` and `mem_rdata_o` are register outputs and change only on ack edges.

## Test plan
- **Reset fetch:** reset, PC = `0x08000000`, zero-wait bus returns `0x00500093`.
  - `stall_o = 5'b11111` for 2 cycles, then 0.
  - `if_ins_o = 0x00500093`.
  - `bus_f3_o = 3'b010`, `bus_we_o = 0`.
- **Load with hit:** instruction hit, `mem_re_i = 1`, address `0x00000010`, bus returns `0xDEADBEEF` after 3 wait cycles.
  - Stall lasts 5 cycles.
  - `mem_rdata_o = 0xDEADBEEF`.
  - `dat_done` clears after the advance.
- **Store with miss:** `mem_wr_i = 1`, data `0x12345678`, f3 `3'b000`, instruction miss in the same cycle.
  - The first bus request has `bus_we_o = 1`, `bus_wdata_o = 0x12345678`, `bus_f3_o = 0`.
  - The second request is the fetch.
  - Total stall is 4 cycles.
- **Branch redirect:** `if_addr_i` jumps from `0x08000008` to `0x08000040`.
  - A new fetch is issued to `0x08000040`.
  - The old buffer is not used.
- **Timeout:** `TIMEOUT = 4`, no ack.
  - `bus_err_o` rises after 4 FETCH cycles and stays high.
  - The FSM retries.
  - A later ack completes normally.
- **Reset mid-access:** assert `rst` during DATA wait, then ack one cycle after reset releases.
  - Ack is ignored.
  - All outputs are at reset values.
  - `dat_done = 0`.
